// File: rtl/dft_pkg.sv
// -----------------------------------------------------------------------------
// dft_pkg
// Shared types and constants for the DFT stimulus/response harness.
//   state_t  : harness run-control FSM states
//   FRM_W    : width of the frame/sample counters
//   CHK_W    : width of the output-frame checksum accumulators
//   sat_inc  : saturating increment for FRM_W-wide counters
// -----------------------------------------------------------------------------
package dft_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_RX = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int FRM_W = 16;
    localparam int CHK_W = 32;

    function automatic logic [FRM_W-1:0] sat_inc(input logic [FRM_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dft_harness_monitor.sv
// -----------------------------------------------------------------------------
// dft_harness_monitor
// Receive side of the DFT harness: checks output-frame framing, counts
// completed frames and (optionally) computes per-frame checksums.
// Optional feature macro: DFT_HARNESS_CHECKSUM_EN (per-frame sums of the
// sign-extended output samples, modulo 2^32; otherwise checksums read 0).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_clear             clears rx count, len_err and checksums (run start)
//   i_count_en          high while a run is active; frames are only counted then
//   i_out_*             DFT output stream (always accepted)
//   o_frame_done        combinational: a counted frame completes this cycle
//   o_rx_frames         saturating count of completed frames this run
//   o_len_err           sticky framing error
//   o_chk_re/o_chk_im   checksums of the last completed counted frame
// -----------------------------------------------------------------------------
module dft_harness_monitor
    import dft_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_count_en,
    input  logic              i_out_valid,
    input  logic              i_out_sop,
    input  logic              i_out_eop,
    input  logic [DATA_W-1:0] i_out_re,
    input  logic [DATA_W-1:0] i_out_im,
    output logic              o_frame_done,
    output logic [FRM_W-1:0]  o_rx_frames,
    output logic              o_len_err,
    output logic [CHK_W-1:0]  o_chk_re,
    output logic [CHK_W-1:0]  o_chk_im
);

    logic             r_in_frame;
    logic [FRM_W-1:0] r_cnt;
    logic [FRM_W-1:0] r_rx_frames;
    logic             r_len_err;

    logic [FRM_W-1:0] w_cnt_next;
    logic             w_take;
    logic             w_frame_end;
    logic             w_frame_done;
    logic             w_bad_start;
    logic             w_len_bad;

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        // A sample belongs to a frame if it opens one or arrives inside one;
        // orphan samples are dropped after flagging the framing error.
        w_take       = i_out_valid && (i_out_sop || r_in_frame);
        w_cnt_next   = i_out_sop ? FRM_W'(1) : sat_inc(r_cnt);
        w_frame_end  = w_take && i_out_eop;
        w_frame_done = w_frame_end && i_count_en;
        // sop inside a frame restarts it; non-sop outside a frame is an orphan.
        w_bad_start  = i_out_valid && (i_out_sop ? r_in_frame : !r_in_frame);
        w_len_bad    = w_frame_end && (w_cnt_next != FRM_W'(FRAME_LEN));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff sees the pre-edge value of every other register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in_frame  <= 1'b0;
            r_cnt       <= '0;
            r_rx_frames <= '0;
            r_len_err   <= 1'b0;
        end else begin
            if (w_take) begin
                r_cnt      <= w_cnt_next;
                r_in_frame <= !i_out_eop;
            end
            if (i_clear) begin
                r_rx_frames <= '0;
                r_len_err   <= 1'b0;
            end else begin
                if (w_bad_start || w_len_bad)
                    r_len_err <= 1'b1;
                if (w_frame_done)
                    r_rx_frames <= sat_inc(r_rx_frames);
            end
        end
    end

    assign o_frame_done = w_frame_done;
    assign o_rx_frames  = r_rx_frames;
    assign o_len_err    = r_len_err;

`ifdef DFT_HARNESS_CHECKSUM_EN
    logic [CHK_W-1:0] r_acc_re;
    logic [CHK_W-1:0] r_acc_im;
    logic [CHK_W-1:0] r_chk_re;
    logic [CHK_W-1:0] r_chk_im;
    logic [CHK_W-1:0] w_acc_re_next;
    logic [CHK_W-1:0] w_acc_im_next;

    always_comb begin
        // sop restarts the running sum; samples are two's complement.
        w_acc_re_next = (i_out_sop ? '0 : r_acc_re) + CHK_W'(signed'(i_out_re));
        w_acc_im_next = (i_out_sop ? '0 : r_acc_im) + CHK_W'(signed'(i_out_im));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_chk_re <= '0;
            r_chk_im <= '0;
        end else begin
            if (w_take) begin
                r_acc_re <= w_acc_re_next;
                r_acc_im <= w_acc_im_next;
            end
            if (i_clear) begin
                r_chk_re <= '0;
                r_chk_im <= '0;
            end else if (w_frame_done) begin
                r_chk_re <= w_acc_re_next;
                r_chk_im <= w_acc_im_next;
            end
        end
    end

    assign o_chk_re = r_chk_re;
    assign o_chk_im = r_chk_im;
`else
    // Sample data is only needed by the checksum; tie it off here.
    logic w_unused_data;
    assign w_unused_data = ^{i_out_re, i_out_im};

    assign o_chk_re = '0;
    assign o_chk_im = '0;
`endif

endmodule

// File: rtl/dft_harness.sv
// -----------------------------------------------------------------------------
// dft_harness
// Stimulus/response wrapper for the any-point DFT core. Sends NUM_FRAMES
// deterministic frames (re = sample index k, im = frame index f) into the
// DFT input stream, monitors the DFT output stream and reports completion.
// Optional feature macro: DFT_HARNESS_CHECKSUM_EN (output-frame checksums,
// implemented in dft_harness_monitor; chk_* read 0 when undefined).
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start                      run start pulse (honoured in IDLE/DONE)
//   o_in_valid, i_in_ready       DFT input handshake
//   o_in_sop, o_in_eop           first/last sample of input frame
//   o_in_re, o_in_im             input sample data
//   i_out_valid/sop/eop/re/im    DFT output stream (always accepted)
//   o_busy, o_done               run in progress / all frames received
//   o_tx_frames, o_rx_frames     frames sent / received this run
//   o_len_err                    sticky output framing error
//   o_chk_re, o_chk_im           checksums of last completed output frame
// -----------------------------------------------------------------------------
module dft_harness
    import dft_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FRAME_LEN  = 12,
    parameter int NUM_FRAMES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_in_valid,
    input  logic              i_in_ready,
    output logic              o_in_sop,
    output logic              o_in_eop,
    output logic [DATA_W-1:0] o_in_re,
    output logic [DATA_W-1:0] o_in_im,
    input  logic              i_out_valid,
    input  logic              i_out_sop,
    input  logic              i_out_eop,
    input  logic [DATA_W-1:0] i_out_re,
    input  logic [DATA_W-1:0] i_out_im,
    output logic              o_busy,
    output logic              o_done,
    output logic [FRM_W-1:0]  o_tx_frames,
    output logic [FRM_W-1:0]  o_rx_frames,
    output logic              o_len_err,
    output logic [CHK_W-1:0]  o_chk_re,
    output logic [CHK_W-1:0]  o_chk_im
);

    localparam logic [FRM_W-1:0] K_LAST = FRM_W'(FRAME_LEN - 1);
    localparam logic [FRM_W-1:0] F_LAST = FRM_W'(NUM_FRAMES - 1);
    localparam logic [FRM_W-1:0] F_ALL  = FRM_W'(NUM_FRAMES);
    localparam logic             ONE_PT = (FRAME_LEN == 1);

    state_t           r_state;
    logic [FRM_W-1:0] r_k;
    logic [FRM_W-1:0] r_f;

    logic [FRM_W-1:0] w_k_inc;
    logic [FRM_W-1:0] w_f_inc;
    logic             w_start_ok;
    logic             w_xfer;
    logic             w_count_en;
    logic             w_frame_done;
    logic             w_rx_hit;

    assign w_k_inc    = r_k + 1'b1;
    assign w_f_inc    = r_f + 1'b1;
    assign w_start_ok = i_start && (r_state == IDLE || r_state == DONE);
    assign w_xfer     = o_in_valid && i_in_ready;
    assign w_count_en = (r_state == SEND) || (r_state == WAIT_RX);
    // Look at the frame completing this cycle so done rises together with
    // rx_frames reaching NUM_FRAMES rather than one cycle later.
    assign w_rx_hit   = (w_frame_done && (o_rx_frames == F_LAST)) || (o_rx_frames == F_ALL);

    // NOTE: the synchronous reset covers every register, including the
    // stimulus outputs, so a mid-run reset aborts the stream immediately.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_f         <= '0;
            o_in_valid  <= 1'b0;
            o_in_sop    <= 1'b0;
            o_in_eop    <= 1'b0;
            o_in_re     <= '0;
            o_in_im     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_tx_frames <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_state     <= SEND;
                        r_k         <= '0;
                        r_f         <= '0;
                        o_in_valid  <= 1'b1;
                        o_in_sop    <= 1'b1;
                        o_in_eop    <= ONE_PT;
                        o_in_re     <= '0;
                        o_in_im     <= '0;
                        o_busy      <= 1'b1;
                        o_done      <= 1'b0;
                        o_tx_frames <= '0;
                    end
                end
                SEND: begin
                    // Outputs only move on a transfer, so a stall holds them.
                    if (w_xfer) begin
                        if (r_k == K_LAST) begin
                            r_k         <= '0;
                            o_tx_frames <= o_tx_frames + 1'b1;
                            if (r_f == F_LAST) begin
                                r_state    <= WAIT_RX;
                                o_in_valid <= 1'b0;
                                o_in_sop   <= 1'b0;
                                o_in_eop   <= 1'b0;
                                o_in_re    <= '0;
                                o_in_im    <= '0;
                            end else begin
                                r_f      <= w_f_inc;
                                o_in_sop <= 1'b1;
                                o_in_eop <= ONE_PT;
                                o_in_re  <= '0;
                                o_in_im  <= DATA_W'(w_f_inc);
                            end
                        end else begin
                            r_k      <= w_k_inc;
                            o_in_sop <= 1'b0;
                            o_in_eop <= (w_k_inc == K_LAST);
                            o_in_re  <= DATA_W'(w_k_inc);
                        end
                    end
                end
                WAIT_RX: begin
                    if (w_rx_hit) begin
                        r_state <= DONE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    dft_harness_monitor #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN)
    ) u_monitor (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_start_ok),
        .i_count_en   (w_count_en),
        .i_out_valid  (i_out_valid),
        .i_out_sop    (i_out_sop),
        .i_out_eop    (i_out_eop),
        .i_out_re     (i_out_re),
        .i_out_im     (i_out_im),
        .o_frame_done (w_frame_done),
        .o_rx_frames  (o_rx_frames),
        .o_len_err    (o_len_err),
        .o_chk_re     (o_chk_re),
        .o_chk_im     (o_chk_im)
    );

endmodule

// File: tb/tb_dft_harness.sv
// -----------------------------------------------------------------------------
// tb_dft_harness
// Directed bench for dft_harness with FRAME_LEN=12, NUM_FRAMES=2. The DFT is
// modelled as a 5-cycle delay line of accepted input samples. Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dft_harness;

    localparam int DW  = 16;
    localparam int FL  = 12;
    localparam int NF  = 2;
    localparam int DLY = 5;

`ifdef DFT_HARNESS_CHECKSUM_EN
    localparam logic [31:0] EXP_CHK_RE = 32'd66;
    localparam logic [31:0] EXP_CHK_IM = 32'd12;
`else
    localparam logic [31:0] EXP_CHK_RE = 32'd0;
    localparam logic [31:0] EXP_CHK_IM = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_ready;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;

    logic          o_in_valid;
    logic          o_in_sop;
    logic          o_in_eop;
    logic [DW-1:0] o_in_re;
    logic [DW-1:0] o_in_im;
    logic          o_busy;
    logic          o_done;
    logic [15:0]   o_tx_frames;
    logic [15:0]   o_rx_frames;
    logic          o_len_err;
    logic [31:0]   o_chk_re;
    logic [31:0]   o_chk_im;

    always #5 clk = ~clk;

    dft_harness #(
        .DATA_W     (DW),
        .FRAME_LEN  (FL),
        .NUM_FRAMES (NF)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_in_valid  (o_in_valid),
        .i_in_ready  (in_ready),
        .o_in_sop    (o_in_sop),
        .o_in_eop    (o_in_eop),
        .o_in_re     (o_in_re),
        .o_in_im     (o_in_im),
        .i_out_valid (out_valid),
        .i_out_sop   (out_sop),
        .i_out_eop   (out_eop),
        .i_out_re    (out_re),
        .i_out_im    (out_im),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_tx_frames (o_tx_frames),
        .o_rx_frames (o_rx_frames),
        .o_len_err   (o_len_err),
        .o_chk_re    (o_chk_re),
        .o_chk_im    (o_chk_im)
    );

    int total = 0;
    int bad   = 0;

    // Delay-line DFT model and scoreboard state.
    logic          dl_v  [DLY];
    logic          dl_s  [DLY];
    logic          dl_e  [DLY];
    logic [DW-1:0] dl_re [DLY];
    logic [DW-1:0] dl_im [DLY];

    logic [15:0] exp_k;
    logic [15:0] exp_f;
    int          nxfer;
    int          vcyc;
    int          rises;
    int          out_idx;
    int          cyc;
    logic        prev_valid;
    logic        hold_pend;
    logic [63:0] held;
    logic        ready_pat;
    logic        trunc;
    logic        pend_trunc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] in_bus();
        return {29'b0, o_in_valid, o_in_sop, o_in_eop, o_in_im, o_in_re};
    endfunction

    task automatic flush();
        for (int i = 0; i < DLY; i++) begin
            dl_v[i]  = 1'b0;
            dl_s[i]  = 1'b0;
            dl_e[i]  = 1'b0;
            dl_re[i] = '0;
            dl_im[i] = '0;
        end
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_re    = '0;
        out_im    = '0;
    endtask

    task automatic new_run();
        exp_k      = '0;
        exp_f      = '0;
        nxfer      = 0;
        vcyc       = 0;
        rises      = 0;
        out_idx    = 0;
        prev_valid = 1'b0;
        hold_pend  = 1'b0;
        pend_trunc = 1'b0;
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic step();
        logic [3:0] pat;
        pat = 4'b1001;  // ready sequence 1,0,0,1 (bit 0 first)
        in_ready = ready_pat ? pat[cyc % 4] : 1'b1;

        if (pend_trunc) begin
            chk("trunc_len_err", {63'b0, o_len_err}, 64'd1);
            chk("trunc_rx", {48'b0, o_rx_frames}, 64'd1);
            pend_trunc = 1'b0;
        end
        if (hold_pend) begin
            chk("stall_hold", in_bus(), held);
            hold_pend = 1'b0;
        end
        if (o_in_valid && !in_ready) begin
            held      = in_bus();
            hold_pend = 1'b1;
        end
        if (o_in_valid) vcyc++;
        if (o_in_valid && !prev_valid) rises++;
        prev_valid = o_in_valid;

        if (o_in_valid && in_ready) begin
            chk("xfer", {30'b0, o_in_sop, o_in_eop, o_in_im, o_in_re},
                {30'b0, exp_k == 16'd0, exp_k == 16'(FL - 1), exp_f, exp_k});
            nxfer++;
            if (exp_k == 16'(FL - 1)) begin
                exp_k = '0;
                exp_f = exp_f + 16'd1;
            end else begin
                exp_k = exp_k + 16'd1;
            end
        end

        out_valid = dl_v[DLY-1];
        out_sop   = dl_s[DLY-1];
        out_eop   = dl_e[DLY-1];
        out_re    = dl_re[DLY-1];
        out_im    = dl_im[DLY-1];
        if (out_valid) begin
            if (trunc && out_idx == FL - 2) begin
                out_eop    = 1'b1;
                pend_trunc = 1'b1;
            end
            out_idx++;
        end
        for (int i = DLY - 1; i > 0; i--) begin
            dl_v[i]  = dl_v[i-1];
            dl_s[i]  = dl_s[i-1];
            dl_e[i]  = dl_e[i-1];
            dl_re[i] = dl_re[i-1];
            dl_im[i] = dl_im[i-1];
        end
        dl_v[0]  = o_in_valid && in_ready;
        dl_s[0]  = o_in_sop;
        dl_e[0]  = o_in_eop;
        dl_re[0] = o_in_re;
        dl_im[0] = o_in_im;

        @(negedge clk);
        cyc++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!o_done && n < budget) begin
            step();
            n++;
        end
        chk("done_reached", {63'b0, o_done}, 64'd1);
    endtask

    task automatic reset_checks(input string p);
        chk({p, "in_valid"}, {63'b0, o_in_valid}, 64'd0);
        chk({p, "in_sop"},   {63'b0, o_in_sop},   64'd0);
        chk({p, "in_eop"},   {63'b0, o_in_eop},   64'd0);
        chk({p, "in_re"},    {48'b0, o_in_re},    64'd0);
        chk({p, "in_im"},    {48'b0, o_in_im},    64'd0);
        chk({p, "busy"},     {63'b0, o_busy},     64'd0);
        chk({p, "done"},     {63'b0, o_done},     64'd0);
        chk({p, "tx"},       {48'b0, o_tx_frames}, 64'd0);
        chk({p, "rx"},       {48'b0, o_rx_frames}, 64'd0);
        chk({p, "len_err"},  {63'b0, o_len_err},  64'd0);
        chk({p, "chk_re"},   {32'b0, o_chk_re},   64'd0);
        chk({p, "chk_im"},   {32'b0, o_chk_im},   64'd0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        start     = 1'b0;
        in_ready  = 1'b1;
        ready_pat = 1'b0;
        trunc     = 1'b0;
        cyc       = 0;
        flush();
        new_run();
        repeat (3) @(negedge clk);
        reset_checks("rst_");
        rst = 1'b0;
        @(negedge clk);

        // Run A: ready always high, back-to-back frames.
        new_run();
        pulse_start();
        chk("a_valid_rise", {63'b0, o_in_valid}, 64'd1);
        chk("a_busy", {63'b0, o_busy}, 64'd1);
        wait_done(300);
        chk("a_tx", {48'b0, o_tx_frames}, 64'd2);
        chk("a_rx", {48'b0, o_rx_frames}, 64'd2);
        chk("a_len_err", {63'b0, o_len_err}, 64'd0);
        chk("a_busy_low", {63'b0, o_busy}, 64'd0);
        chk("a_xfers", 64'(nxfer), 64'd24);
        chk("a_valid_cycles", 64'(vcyc), 64'd24);
        chk("a_valid_rises", 64'(rises), 64'd1);
        chk("a_chk_re", {32'b0, o_chk_re}, {32'b0, EXP_CHK_RE});
        chk("a_chk_im", {32'b0, o_chk_im}, {32'b0, EXP_CHK_IM});
        step();
        chk("a_done_hold", {63'b0, o_done}, 64'd1);

        // Run B: start from DONE clears counters; ready toggles 1,0,0,1.
        new_run();
        ready_pat = 1'b1;
        pulse_start();
        chk("b_tx_clr", {48'b0, o_tx_frames}, 64'd0);
        chk("b_rx_clr", {48'b0, o_rx_frames}, 64'd0);
        chk("b_done_clr", {63'b0, o_done}, 64'd0);
        chk("b_busy", {63'b0, o_busy}, 64'd1);
        chk("b_chk_re_clr", {32'b0, o_chk_re}, 64'd0);
        wait_done(400);
        ready_pat = 1'b0;
        chk("b_xfers", 64'(nxfer), 64'd24);
        chk("b_tx", {48'b0, o_tx_frames}, 64'd2);
        chk("b_rx", {48'b0, o_rx_frames}, 64'd2);
        chk("b_len_err", {63'b0, o_len_err}, 64'd0);

        // Run C: start pulsed in SEND is ignored.
        new_run();
        pulse_start();
        n = 0;
        while (nxfer < 5 && n < 50) begin
            step();
            n++;
        end
        pulse_start();
        chk("c_busy", {63'b0, o_busy}, 64'd1);
        chk("c_tx_mid", {48'b0, o_tx_frames}, 64'd0);
        wait_done(300);
        chk("c_xfers", 64'(nxfer), 64'd24);
        chk("c_tx", {48'b0, o_tx_frames}, 64'd2);
        chk("c_rx", {48'b0, o_rx_frames}, 64'd2);

        // Run D: first output frame ends after 11 samples.
        new_run();
        trunc = 1'b1;
        pulse_start();
        wait_done(300);
        trunc = 1'b0;
        chk("d_len_err", {63'b0, o_len_err}, 64'd1);
        chk("d_tx", {48'b0, o_tx_frames}, 64'd2);
        chk("d_rx", {48'b0, o_rx_frames}, 64'd2);

        // Run E: reset at sample 7 of frame 0, then restart.
        new_run();
        pulse_start();
        n = 0;
        while (!(o_in_valid && o_in_re == 16'd7) && n < 50) begin
            step();
            n++;
        end
        chk("e_reached_k7", {48'b0, o_in_re}, 64'd7);
        rst = 1'b1;
        flush();
        @(negedge clk);
        reset_checks("e_rst_");
        rst = 1'b0;
        new_run();
        chk("e_restart_setup", {63'b0, o_in_valid}, 64'd0);
        pulse_start();
        chk("e_restart_sample", in_bus(), {29'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0});
        wait_done(300);
        chk("e_xfers", 64'(nxfer), 64'd24);
        chk("e_rx", {48'b0, o_rx_frames}, 64'd2);
        chk("e_len_err", {63'b0, o_len_err}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dft_harness.md
# dft_harness

Synthesizable stimulus/response wrapper for the any-point DFT core. It generates a programmed number of deterministic complex input frames toward the DFT's streaming input and accepts the DFT's output frames. It also counts transmitted and received frames, checks output frame framing, and reports completion. It sits between the top-level test control and the DFT core, replacing file-based stimuli and dumping in hardware runs.

## Interface
Parameters:
- DATA_W, 16, width of each real/imag sample.
- FRAME_LEN, 12, DFT points per frame (LTE sizes, 12..1200).
- NUM_FRAMES, 4, frames sent per run (1..65535).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begins a run (honoured in IDLE or DONE only).
- in_valid  out  1  sample to DFT valid.
- in_ready  in  1  DFT accepts sample.
- in_sop / in_eop  out  1  first / last sample of frame.
- in_re / in_im  out  DATA_W  sample data.
- out_valid  in  1  DFT output sample valid (always accepted).
- out_sop / out_eop  in  1  DFT output frame markers.
- out_re / out_im  in  DATA_W  DFT output data, two's complement.
- busy  out  1  run in progress.
- done  out  1  all frames received.
- tx_frames / rx_frames  out  16  frames sent / received this run.
- len_err  out  1  sticky framing error.
- chk_re / chk_im  out  32  checksum of last completed output frame.

## Operation
- FSM: IDLE → SEND on start; SEND → WAIT_RX when the last sample of frame NUM_FRAMES-1 is accepted; WAIT_RX → DONE when rx_frames == NUM_FRAMES; DONE → SEND on start.
- On each start, clear tx_frames, rx_frames, len_err, chk_re and chk_im, and reset the sample index k and the frame index f.
- Stimulus sample: in_re = k zero-extended/truncated to DATA_W; in_im = f truncated to DATA_W.
- in_sop = (k==0); in_eop = (k==FRAME_LEN-1).
- Transfer occurs on in_valid && in_ready. While in_valid && !in_ready, hold all in_* signals stable.
- After each transfer, k increments. On eop, k wraps to 0, f increments and tx_frames increments. Frames are sent back-to-back with no idle gap.
- Receive side: start a frame on out_valid && out_sop. Count samples. On out_eop, set len_err if the count is not equal to FRAME_LEN. Then increment rx_frames and latch the checksums.
- Set len_err when out_valid arrives without sop while not inside a frame, or when sop arrives mid-frame. A sop arriving mid-frame restarts the frame.
- rx_frames saturates at 65535. Frames received in IDLE or DONE are counted only for len_err and are otherwise ignored.
- start is ignored in SEND and WAIT_RX.

## Timing
- Reset values: in_valid=0, in_sop=0, in_eop=0, in_re=0, in_im=0, busy=0, done=0, tx_frames=0, rx_frames=0, len_err=0, chk_re=0, chk_im=0; state=IDLE.
- All outputs are registered.
- in_valid rises the cycle after start is sampled.
- Next-sample update is zero-latency: the cycle after an accepted sample presents the next sample.
- rx_frames, chk_re and chk_im update the cycle after out_eop is sampled.
- done rises the cycle rx_frames reaches NUM_FRAMES and stays high until start or rst.
- busy is high in SEND and WAIT_RX.
- rst mid-run aborts immediately and forces all reset values.

## Configuration
- DFT_HARNESS_CHECKSUM_EN defined: implement per-frame 32-bit accumulators. Sign-extend out_re and out_im and sum them modulo 2^32. Latch the sums into chk_re and chk_im at eop.
- Not defined: omit the accumulators; chk_re and chk_im are constant 0. All other behaviour is identical.

## Structure
- Shared package dft_pkg holds:
  - FSM state enum (IDLE, SEND, WAIT_RX, DONE);
  - frame-counter width constant (16);
  - checksum width constant (32).
- Split into one natural sub-module, dft_harness_monitor, covering the receive framing check, frame counter and checksum.
- Stimulus generation and the FSM stay in the top module.

## Test plan
- FRAME_LEN=12, NUM_FRAMES=2, in_ready=1, DFT modelled as a 5-cycle delay of the input stream → input frame 0 is re 0..11 with im 0, then frame 1 is re 0..11 with im 1. Expected: 24 consecutive valid cycles, tx_frames=2, rx_frames=2, done=1, len_err=0.
- Same setup with the checksum macro defined → after frame 1, chk_re=66 and chk_im=12. Without the macro, both read 0.
- in_ready toggling 1,0,0,1 → no samples dropped or duplicated; data held stable during stalls; still exactly 24 transfers.
- Output frame with eop after 11 samples → len_err=1 and rx_frames still increments.
- rst asserted at sample 7 of frame 0 → next cycle all outputs are at reset values. A subsequent start restarts from re=0, im=0.
- start pulsed during SEND → ignored, tx_frames unaffected. start pulsed in DONE → counters cleared and a new run begins.
